// File: rtl/usb_bit_stuffer_pkg.sv
// Shared types and defaults for the USB transmit bit-stuffing stage.
package usb_pkg;

  typedef enum logic [1:0] {
    STF_IDLE,
    STF_PASS,
    STF_STUFF
  } stuff_state_t;

  localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/usb_bit_stuffer_ones_run_counter.sv
// Saturating count of consecutive 1s; hit flags that the count being loaded equals RUN_LEN.
module usb_ones_run_counter
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_STUFF_RUN,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             bit_in,
  input  logic             en,
  output logic [CNT_W-1:0] run,
  output logic             hit
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

  logic [CNT_W-1:0] run_next;

  always_comb begin
    run_next = run;
    if (clr) begin
      run_next = '0;
    end else if (load) begin
      run_next = CNT_W'(bit_in);
    end else if (en) begin
      if (!bit_in)             run_next = '0;
      else if (run != RUN_MAX) run_next = run + CNT_W'(1);
    end
  end

  assign hit = (run_next == RUN_MAX);

  always_ff @(posedge clk) begin
    if (rst) run <= '0;
    else     run <= run_next;
  end

endmodule

// File: rtl/usb_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after RUN_LEN consecutive 1s, stalling the source meanwhile.
// Define BIT_STUFF_NRZI_EN to drive out_bit as the NRZI line level instead of the raw stuffed bit.
module usb_bit_stuffer
  import usb_pkg::*;
#(
  parameter int RUN_LEN = USB_STUFF_RUN,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_sop,
  input  logic in_last,
  output logic in_ready,
  output logic out_valid,
  output logic out_bit,
  output logic out_last,
  output logic stuffing
);

  stuff_state_t     state, state_next;
  logic             stuff_last;
  logic             accept, take, hit;
  logic [CNT_W-1:0] run;
  logic             valid_d, bit_d, last_d, stuffing_d;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= STF_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      STF_IDLE, STF_PASS: begin
        if (take) begin
          if (hit)          state_next = STF_STUFF;
          else if (in_last) state_next = STF_IDLE;
          else              state_next = STF_PASS;
        end
      end
      STF_STUFF: state_next = stuff_last ? STF_IDLE : STF_PASS;
      default:   state_next = STF_IDLE;
    endcase
  end

  // take: an accepted bit that belongs to a packet (a bare bit in IDLE is dropped).
  always_comb begin
    in_ready   = (state != STF_STUFF);
    accept     = in_valid && in_ready;
    take       = accept && (in_sop || state == STF_PASS);
    stuffing_d = (state == STF_STUFF);
    valid_d    = take || stuffing_d;
    bit_d      = take && in_bit;
    last_d     = (take && in_last && !hit) || (stuffing_d && stuff_last);
  end

  usb_ones_run_counter #(
    .RUN_LEN (RUN_LEN),
    .CNT_W   (CNT_W)
  ) u_run (
    .clk    (clk),
    .rst    (rst),
    .clr    (stuffing_d),
    .load   (accept && in_sop),
    .bit_in (in_bit),
    .en     (take && !in_sop),
    .run    (run),
    .hit    (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      stuffing   <= 1'b0;
      stuff_last <= 1'b0;
    end else begin
      out_valid <= valid_d;
      out_last  <= last_d;
      stuffing  <= stuffing_d;
      if (take && hit) stuff_last <= in_last;
    end
  end

`ifdef BIT_STUFF_NRZI_EN
  // The line returns to J (1) right after a packet's final bit, before any new bit is encoded.
  logic level_base;
  assign level_base = out_last ? 1'b1 : out_bit;

  always_ff @(posedge clk) begin
    if (rst)          out_bit <= 1'b1;
    else if (valid_d) out_bit <= bit_d ? level_base : ~level_base;
    else              out_bit <= level_base;
  end
`else
  always_ff @(posedge clk) begin
    if (rst) out_bit <= 1'b0;
    else     out_bit <= bit_d;
  end
`endif

  run_bounded: assert property (@(posedge clk) disable iff (rst) run <= CNT_W'(RUN_LEN));

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Self-checking bench for usb_bit_stuffer: packet-rule model with per-cycle compare plus literal vectors.
module tb_usb_bit_stuffer;

  localparam int RUN_LEN = 6;
`ifdef BIT_STUFF_NRZI_EN
  localparam bit RAW = 1'b0;
`else
  localparam bit RAW = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_bit, in_sop, in_last;
  logic in_ready, out_valid, out_bit, out_last, stuffing;

  usb_bit_stuffer #(.RUN_LEN(RUN_LEN), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sop    (in_sop),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .stuffing  (stuffing)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic b;
    logic stf;
    logic last;
  } exp_t;

  exp_t q[$];
  exp_t item;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  bit   stall_due = 1'b0;
  bit   m_in_pkt = 1'b0;
  int   m_run = 0;
  logic lvl = 1'b1;
  bit   lvl_ret = 1'b0;
  int   lvl_rst_cyc = -1;
  logic [31:0] cap_bits, cap_stf, cap_last;
  int   cap_n = 0;
  logic ev, eb, es, el;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected output stream derived from the stuffing rules, one entry per output bit.
  task automatic model_accept(input logic b, input logic s, input logic l);
    bit hit;
    if (s) begin
      m_in_pkt = 1'b1;
      m_run    = 0;
    end
    if (m_in_pkt) begin
      m_run = b ? m_run + 1 : 0;
      hit   = (m_run == RUN_LEN);
      q.push_back('{cyc + 1, b, 1'b0, l && !hit});
      if (hit) begin
        q.push_back('{cyc + 2, 1'b0, 1'b1, l});
        m_run     = 0;
        stall_due = 1'b1;
      end
      if (l) m_in_pkt = 1'b0;
    end
  endtask

  task automatic beat(input logic v, input logic b, input logic s, input logic l);
    logic exp_r;
    in_valid = v; in_bit = b; in_sop = s; in_last = l;
    exp_r     = !stall_due;
    stall_due = 1'b0;
    check("in_ready", 32'(in_ready), 32'(exp_r));
    if (!exp_r) begin
      @(posedge clk); #1;
      check("in_ready_after_stuff", 32'(in_ready), 32'd1);
    end
    if (v) model_accept(b, s, l);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sop = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [31:0] bits, input int n, input logic with_last);
    for (int i = 0; i < n; i++)
      beat(1'b1, bits[i], i == 0, with_last && (i == n - 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_sop = 1'b0; in_last = 1'b0; in_bit = 1'b0;
    while (q.size() > 0 && q[$].cyc > cyc) void'(q.pop_back());
    m_in_pkt    = 1'b0;
    m_run       = 0;
    stall_due   = 1'b0;
    lvl_rst_cyc = cyc + 1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic lit(input string name, input int n, input logic [31:0] b,
                     input logic [31:0] s, input logic [31:0] l, input bit chk_b);
    check({name, "_count"}, 32'(cap_n), 32'(n));
    check({name, "_stuffing"}, cap_stf, s);
    check({name, "_last"}, cap_last, l);
    if (chk_b) check({name, "_bits"}, cap_bits, b);
    cap_n = 0; cap_bits = '0; cap_stf = '0; cap_last = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == lvl_rst_cyc) begin
        lvl     = 1'b1;
        lvl_ret = 1'b0;
      end
      if (lvl_ret) begin
        lvl     = 1'b1;
        lvl_ret = 1'b0;
      end
      ev = 1'b0; eb = 1'b0; es = 1'b0; el = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        item = q.pop_front();
        ev = 1'b1; eb = item.b; es = item.stf; el = item.last;
        if (!item.b) lvl = ~lvl;
        if (item.last) lvl_ret = 1'b1;
      end
      if (!RAW) eb = lvl;
      check("out{valid,bit,stuffing,last}", {28'd0, out_valid, out_bit, stuffing, out_last},
            {28'd0, ev, eb, es, el});
      if (out_valid && cap_n < 32) begin
        cap_bits[cap_n] = out_bit;
        cap_stf[cap_n]  = stuffing;
        cap_last[cap_n] = out_last;
        cap_n++;
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sop = 1'b0; in_last = 1'b0;
    cap_bits = '0; cap_stf = '0; cap_last = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_last", 32'(out_last), 32'd0);
    check("reset_stuffing", 32'(stuffing), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_bit", 32'(out_bit), RAW ? 32'd0 : 32'd1);
    rst = 1'b0;
    chk_en = 1'b1;

    send(32'h01, 8, 1'b1);            idle(3); lit("t1_plain", 8, 32'h01, 32'h0, 32'h80, RAW);
    send(32'hBF, 8, 1'b1);            idle(3); lit("t2_one_stuff", 9, 32'h13F, 32'h040, 32'h100, RAW);
    send(32'hFFF, 12, 1'b1);          idle(3); lit("t3_twelve_ones", 14, 32'h1FBF, 32'h2040, 32'h2000, RAW);
    send(32'h7E, 7, 1'b1);            idle(3); lit("t4_trailing_stuff", 8, 32'h7E, 32'h80, 32'h80, RAW);
    beat(1'b1, 1'b1, 1'b0, 1'b0);     idle(3); lit("t4_idle_drop", 0, 32'h0, 32'h0, 32'h0, RAW);

    send(32'h0F, 4, 1'b0);
    do_reset();
    send(32'h3F, 6, 1'b1);            idle(3); lit("t5_reset_mid", 11, 32'h3FF, 32'h400, 32'h400, RAW);

    // Gap inside a packet holds the run: 3 ones, gap, 3 ones still trigger a stuff.
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b1);     idle(3); lit("t7_gap", 8, 32'h3F, 32'h40, 32'h80, RAW);

    send(32'h07, 3, 1'b0);
    send(32'h0F, 5, 1'b1);            idle(3); lit("t8_abandon", 8, 32'h7F, 32'h0, 32'h80, RAW);

    send(32'h1, 1, 1'b1);
    send(32'h0, 1, 1'b1);             idle(3); lit("t9_one_bit", 2, 32'h1, 32'h0, 32'h3, RAW);

    send(32'h6, 4, 1'b1);             idle(3);
    lit("t6_nrzi", 4, RAW ? 32'h6 : 32'h8, 32'h0, 32'h8, 1'b1);

    check("drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
